// File: rtl/sync_mem_array.sv
// DEPTH x DATA_W masked-write memory. After reset it clears itself in DEPTH cycles. Writes take 1 cycle.
// Reads return 1 cycle after acceptance. ready drops for one cycle after each read, so reads run at most one per 2 cycles.
module sync_mem_array #(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 3,
  parameter int unsigned       DEPTH    = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              RW,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] wmask,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              init_done
);

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_RDOUT} state_t;

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH-1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic                init_done_q, init_done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdat;
  logic                accept;
  logic                in_range;
  logic [ADDR_W-1:0]   rd_idx;

  assign accept   = req & (state_q == ST_IDLE);
  assign in_range = ({1'b0, addr} < DEPTH_L);
  // Keep the array index legal even when the request itself is out of range.
  assign rd_idx   = in_range ? addr : '0;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    init_done_d = init_done_q;
    rdata_d     = rdata_q;
    mem_we      = 1'b0;
    mem_waddr   = rd_idx;
    mem_wdat    = (mem_q[rd_idx] & ~wmask) | (wdata & wmask);
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdat  = INIT_VAL;
        ptr_d     = ptr_q + ADDR_W'(1);
        if (ptr_q == LAST_PTR) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
          ptr_d       = '0;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          err_d = ~in_range;
          if (in_range) begin
            if (RW) begin
              mem_we = 1'b1;
            end else begin
              rdata_d  = mem_q[rd_idx];
              rvalid_d = 1'b1;
              state_d  = ST_RDOUT;
            end
          end
        end
      end
      ST_RDOUT: state_d = ST_IDLE;
      default:  state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      init_done_q <= init_done_d;
      rdata_q     <= rdata_d;
    end
  end

  // Array contents are defined by the clear sequence, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdat;
  end

  assign ready     = (state_q == ST_IDLE);
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_sync_mem_array.sv
// Randomised bench for sync_mem_array (DEPTH=6, ADDR_W=3, INIT_VAL=A5) against an array-based reference model.
module tb_sync_mem_array;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 6;
  localparam logic [7:0]  INIT   = 8'hA5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic              RW = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] wmask = '0;
  logic              ready, rvalid, err, init_done;
  logic [DATA_W-1:0] rdata;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] ref_mem [DEPTH];
  logic [7:0] ref_rdata;

  sync_mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .INIT_VAL(INIT)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .RW(RW), .addr(addr), .wdata(wdata), .wmask(wmask),
    .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT;
    ref_rdata = 8'h00;
  endtask

  // Asserts reset away from a clock edge and checks every output reset value.
  task automatic apply_reset();
    rst_n = 1'b0;
    req   = 1'b0;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_init_done", init_done, 0);
    model_clear();
  endtask

  // Counts rising edges from reset release until ready; expects exactly DEPTH.
  task automatic wait_clear();
    int cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cnt++;
      if (ready) break;
    end
    req = 1'b0;
    chk("clear_cycles", cnt, DEPTH);
    chk("init_done", init_done, 1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) chk("ready_timeout", ready, 1);
  endtask

  // One request, issued at posedge+1 and accepted on the next edge; model and checks follow.
  task automatic access(input logic rw, input logic [2:0] a, input logic [7:0] d, input logic [7:0] m);
    logic inr;
    wait_ready();
    inr   = (int'(a) < DEPTH);
    req   = 1'b1; RW = rw; addr = a; wdata = d; wmask = m;
    @(posedge clk); #1;
    req   = 1'b0;
    chk("err", err, {31'b0, ~inr});
    if (rw) begin
      if (inr) ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
      chk("wr_rvalid", rvalid, 0);
      chk("wr_ready", ready, 1);
    end else if (inr) begin
      ref_rdata = ref_mem[a];
      chk("rd_rvalid", rvalid, 1);
      chk("rd_rdata", rdata, ref_rdata);
      chk("rd_ready_low", ready, 0);
      @(posedge clk); #1;
      chk("rd_rvalid_pulse", rvalid, 0);
      chk("rd_ready_back", ready, 1);
    end else begin
      chk("oor_rvalid", rvalid, 0);
      chk("oor_rdata_hold", rdata, ref_rdata);
      chk("oor_ready", ready, 1);
    end
  endtask

  initial begin
    ref_rdata = 8'h00;
    #2;
    apply_reset();
    // Interrupt the clear sequence once four words have been written.
    #2 rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("midclear_ready", ready, 0);
    apply_reset();
    chk("midclear_init_done", init_done, 0);
    // Requests held during CLEAR must be ignored.
    req = 1'b1; RW = 1'b1; addr = 3'd0; wdata = 8'h00; wmask = 8'hFF;
    #2 rst_n = 1'b1;
    wait_clear();

    for (int a = 0; a < DEPTH; a++) access(1'b0, 3'(a), 8'h00, 8'h00);

    access(1'b1, 3'd3, 8'hFF, 8'h0F);
    access(1'b0, 3'd3, 8'h00, 8'h00);
    access(1'b1, 3'd3, 8'h00, 8'h01);
    access(1'b0, 3'd3, 8'h00, 8'h00);
    access(1'b1, 3'd2, 8'h00, 8'h00);
    access(1'b0, 3'd2, 8'h00, 8'h00);

    for (int a = 0; a < DEPTH; a++) access(1'b1, 3'(a), 8'(8'h10 + a), 8'hFF);
    access(1'b0, 3'd0, 8'h00, 8'h00);
    access(1'b0, 3'd1, 8'h00, 8'h00);

    access(1'b1, 3'd5, 8'h3C, 8'hFF);
    access(1'b0, 3'd5, 8'h00, 8'h00);

    access(1'b1, 3'd7, 8'h77, 8'hFF);
    access(1'b0, 3'd6, 8'h00, 8'h00);
    for (int a = 0; a < DEPTH; a++) access(1'b0, 3'(a), 8'h00, 8'h00);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        chk("idle_rvalid", rvalid, 0);
      end else begin
        access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
               ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
      end
    end

    // Reset while a read is being returned.
    wait_ready();
    req = 1'b1; RW = 1'b0; addr = 3'd2;
    @(posedge clk); #1;
    req = 1'b0;
    chk("rdout_rvalid", rvalid, 1);
    apply_reset();
    #2 rst_n = 1'b1;
    wait_clear();
    for (int a = 0; a < DEPTH; a++) access(1'b0, 3'(a), 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
